conv_bf16tomxint_stream: RTL and testbench

- Streaming successor to the bf16-to-MXINT converter.
- Accepts one MX block of k bf16 elements over k/lanes input beats on a valid/ready interface, buffers it and tracks the running max exponent.
- Then emits k/lanes output beats of bit_width-bit signed elements plus the shared E8M0 scale, with output backpressure.
- Adds NaN/Inf scale propagation and subnormal handling; sits between bf16 producers and MX compute/storage.

---
 rtl/conv_bf16tomxint_stream_pkg.sv | 43 ++++
 rtl/conv_bf16tomxint_stream_if.sv | 28 ++
 rtl/mx_block_buffer.sv | 32 +++
 rtl/shift_rnd_rne.sv | 38 +++
 rtl/unsigned_max.sv | 32 +++
 rtl/conv_bf16tomxint_stream.sv | 145 ++++++++++++++
 tb/tb_conv_bf16tomxint_stream.sv | 292 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/conv_bf16tomxint_stream_pkg.sv
// Shared bf16 / E8M0 field layout, FSM states and element decode
// for the streaming bf16 to MXINT converter.
package conv_bf16tomxint_stream_pkg;

    localparam int BF16_W    = 16;
    localparam int SGN_BIT   = 15;
    localparam int EXP_LSB   = 7;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 7;
    localparam int MAN_EXT_W = MAN_W + 2;
    localparam int E8M0_W    = 8;
    localparam logic [E8M0_W-1:0] E8M0_NAN = 8'hFF;

    typedef enum logic {FILL, DRAIN} state_e;

    typedef struct packed {
        logic                        sgn;
        logic [EXP_W-1:0]            eff_exp;
        logic signed [MAN_EXT_W-1:0] signed_man;
    } bf16_dec_t;

    // Subnormals share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] bf16_eff_exp(
        input logic [BF16_W-1:0] x
    );
        logic [EXP_W-1:0] e;
        e = x[EXP_LSB +: EXP_W];
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    function automatic bf16_dec_t bf16_decode(
        input logic [BF16_W-1:0] x
    );
        bf16_dec_t            d;
        logic [MAN_EXT_W-1:0] ext;
        ext          = {1'b0, x[EXP_LSB +: EXP_W] != '0, x[MAN_W-1:0]};
        d.sgn        = x[SGN_BIT];
        d.eff_exp    = bf16_eff_exp(x);
        d.signed_man = d.sgn ? -$signed(ext) : $signed(ext);
        return d;
    endfunction

endpackage

// File: rtl/conv_bf16tomxint_stream_if.sv
// Input and output beat streams of the converter, each with
// its own valid/ready pair.
interface conv_bf16tomxint_stream_if #(
    parameter int bit_width = 8,
    parameter int lanes     = 8
);
    import conv_bf16tomxint_stream_pkg::*;

    logic                             i_valid;
    logic                             o_ready;
    logic [lanes-1:0][BF16_W-1:0]     i_bf16_vec;
    logic                             o_valid;
    logic                             i_ready;
    logic [lanes-1:0][bit_width-1:0]  o_mx_vec;
    logic [E8M0_W-1:0]                o_mx_exp;
    logic                             o_last;

    modport slave (
        input  i_valid, i_bf16_vec, i_ready,
        output o_ready, o_valid, o_mx_vec, o_mx_exp, o_last
    );

    modport master (
        output i_valid, i_bf16_vec, i_ready,
        input  o_ready, o_valid, o_mx_vec, o_mx_exp, o_last
    );

endinterface

// File: rtl/mx_block_buffer.sv
// One MX block of raw elements, written and read one beat
// (lanes elements) at a time.
module mx_block_buffer #(
    parameter int lanes = 8,
    parameter int depth = 4,
    parameter int width = 16,
    parameter int aw    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          we,
    input  logic [aw-1:0]                 waddr,
    input  logic [lanes-1:0][width-1:0]   wdata,
    input  logic [aw-1:0]                 raddr,
    output logic [lanes-1:0][width-1:0]   rdata
);
    logic [lanes-1:0][width-1:0] mem [depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/shift_rnd_rne.sv
// Signed right shift with round-to-nearest-even and narrowing
// from width_i to width_o; result saturates to the output range.
module shift_rnd_rne #(
    parameter int width_i     = 9,
    parameter int width_o     = 8,
    parameter int width_shift = 8
) (
    input  logic signed [width_i-1:0]  din,
    input  logic [width_shift-1:0]     shift,
    output logic signed [width_o-1:0]  dout
);
    localparam int DROP = width_i - width_o;
    localparam int OMAX = (1 << (width_o - 1)) - 1;
    localparam int OMIN = -(1 << (width_o - 1));

    int                 sh;
    int                 s;
    logic signed [31:0] x;
    logic signed [31:0] q;
    logic signed [31:0] r;
    logic signed [31:0] half;

    // Floor quotient keeps the remainder non-negative for both signs.
    always_comb begin
        sh   = int'(shift);
        s    = sh + DROP;
        x    = {{(32-width_i){din[width_i-1]}}, din};
        q    = x >>> s;
        r    = x - (q <<< s);
        half = (s > 0) ? (32'sd1 <<< (s - 1)) : 32'sd0;
        if (s > 0 && (r > half || (r == half && q[0]))) q = q + 32'sd1;
        if (sh >= width_i) q = 32'sd0;
        if (q > OMAX) q = OMAX;
        if (q < OMIN) q = OMIN;
        dout = q[width_o-1:0];
    end

endmodule

// File: rtl/unsigned_max.sv
// Maximum of n unsigned values, optionally registered.
module unsigned_max #(
    parameter int width       = 8,
    parameter int n           = 2,
    parameter bit flop_output = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [n-1:0][width-1:0]   din,
    output logic [width-1:0]          dout
);
    logic [width-1:0] m;

    always_comb begin
        m = '0;
        for (int i = 0; i < n; i++) begin
            if (din[i] > m) m = din[i];
        end
    end

    if (flop_output) begin : g_ff
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout <= '0;
            else        dout <= m;
        end
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign dout = m;
    end

endmodule

// File: rtl/conv_bf16tomxint_stream.sv
// Streams one k-element bf16 block in, then streams it out as
// bit_width-bit MXINT elements with a shared E8M0 scale.
module conv_bf16tomxint_stream #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    conv_bf16tomxint_stream_if.slave    bus
);
    import conv_bf16tomxint_stream_pkg::*;

    localparam int NB = k / lanes;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_e                          state;
    state_e                          state_nx;
    logic [CW-1:0]                   beat_cnt;
    logic [E8M0_W-1:0]               run_max;
    logic [E8M0_W-1:0]               max_nx;
    logic                            nan_flag;
    logic                            beat_nan;
    logic                            last_beat;
    logic                            in_fire;
    logic                            out_fire;
    logic [lanes:0][EXP_W-1:0]       max_in;
    logic [lanes-1:0][BF16_W-1:0]    rd_vec;
    logic [lanes-1:0][bit_width-1:0] q_vec;
    logic [lanes-1:0]                unused_sgn;

    assign last_beat = (beat_cnt == CW'(NB - 1));
    assign in_fire   = bus.i_valid && (state == FILL);
    assign out_fire  = bus.i_ready && (state == DRAIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FILL;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        unique case (state)
            FILL: begin
                bus.o_ready = 1'b1;
                if (in_fire && last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                bus.o_valid = 1'b1;
                if (out_fire && last_beat) state_nx = FILL;
            end
        endcase
    end

    // Slot lanes holds the running max so the beat folds in on the same edge.
    always_comb begin
        beat_nan = 1'b0;
        max_in   = '0;
        for (int i = 0; i < lanes; i++) begin
            max_in[i] = bf16_eff_exp(bus.i_bf16_vec[i]);
            beat_nan |= (bus.i_bf16_vec[i][EXP_LSB +: EXP_W] == '1);
        end
        max_in[lanes] = run_max;
    end

    unsigned_max #(
        .width       (EXP_W),
        .n           (lanes + 1),
        .flop_output (1'b0)
    ) u_max (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (max_in),
        .dout  (max_nx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt <= '0;
            run_max  <= '0;
            nan_flag <= 1'b0;
        end else if (in_fire) begin
            run_max  <= max_nx;
            nan_flag <= nan_flag | beat_nan;
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
        end else if (out_fire) begin
            if (last_beat) begin
                beat_cnt <= '0;
                run_max  <= '0;
                nan_flag <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    mx_block_buffer #(
        .lanes (lanes),
        .depth (NB),
        .width (BF16_W),
        .aw    (CW)
    ) u_buf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (out_fire && last_beat),
        .we    (in_fire),
        .waddr (beat_cnt),
        .wdata (bus.i_bf16_vec),
        .raddr (beat_cnt),
        .rdata (rd_vec)
    );

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        bf16_dec_t         dec;
        logic [EXP_W-1:0]  shamt;

        assign dec           = bf16_decode(rd_vec[i]);
        assign shamt         = run_max - dec.eff_exp;
        assign unused_sgn[i] = dec.sgn;

        shift_rnd_rne #(
            .width_i     (MAN_EXT_W),
            .width_o     (bit_width),
            .width_shift (EXP_W)
        ) u_rnd (
            .din   (dec.signed_man),
            .shift (shamt),
            .dout  (q_vec[i])
        );
    end

    always_comb begin
        bus.o_mx_vec = '0;
        bus.o_mx_exp = '0;
        bus.o_last   = 1'b0;
        if (state == DRAIN) begin
            bus.o_mx_exp = nan_flag ? E8M0_NAN : run_max;
            bus.o_last   = last_beat;
            if (!nan_flag) bus.o_mx_vec = q_vec;
        end
    end

endmodule

// File: tb/tb_conv_bf16tomxint_stream.sv
// Random and directed blocks against a real-arithmetic reference,
// checked by a scoreboard monitor on the output stream.
module tb_conv_bf16tomxint_stream;

    localparam int BW = 8;
    localparam int K  = 32;
    localparam int L  = 8;
    localparam int NB = K / L;

    localparam int RDY_ON   = 0;
    localparam int RDY_RAND = 1;
    localparam int RDY_OFF  = 2;

    typedef struct {
        logic [L-1:0][BW-1:0] vec;
        logic [7:0]           scale;
        logic                 last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_bf16tomxint_stream_if #(.bit_width(BW), .lanes(L)) bus();

    conv_bf16tomxint_stream #(
        .bit_width (BW),
        .k         (K),
        .lanes     (L)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = RDY_ON;
    int          stall_left = 0;
    int          out_idx = 0;
    logic [15:0] blk [K];

    bit                   held = 1'b0;
    logic [L-1:0][BW-1:0] h_vec;
    logic [7:0]           h_exp;
    logic                 h_last;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // value = sm / 2^t rounded half-to-even, clamped to BW bits
    function automatic int rne_q(input int sm, input int t);
        real v, den, fl, d;
        int  r;
        den = 1.0;
        for (int i = 0; i < t; i++) den = den * 2.0;
        v  = real'(sm) / den;
        fl = $floor(v);
        r  = int'(fl);
        d  = v - fl;
        if (d > 0.5 || (d == 0.5 && (r % 2) != 0)) r++;
        if (r > (1 << (BW - 1)) - 1) r = (1 << (BW - 1)) - 1;
        if (r < -(1 << (BW - 1))) r = -(1 << (BW - 1));
        return r;
    endfunction

    function automatic void push_expected();
        int   emax = 0;
        bit   nan = 1'b0;
        int   ex, eff, m, sm, sh, r, idx;
        exp_t it;
        for (int i = 0; i < K; i++) begin
            ex  = int'(blk[i][14:7]);
            eff = (ex == 0) ? 1 : ex;
            if (eff > emax) emax = eff;
            if (ex == 255) nan = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            it.last  = (b == NB - 1);
            it.scale = nan ? 8'hFF : 8'(emax);
            for (int l = 0; l < L; l++) begin
                idx = b * L + l;
                ex  = int'(blk[idx][14:7]);
                eff = (ex == 0) ? 1 : ex;
                m   = int'(blk[idx][6:0]) + ((ex != 0) ? 128 : 0);
                sm  = blk[idx][15] ? -m : m;
                sh  = emax - eff;
                r   = 0;
                if (!nan && sh < 9) r = rne_q(sm, sh + 9 - BW);
                it.vec[l] = r[BW-1:0];
            end
            sb.push_back(it);
        end
    endfunction

    function automatic logic [15:0] rand_bf16(input int lo, input int hi);
        logic [7:0] ex;
        ex = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(lo, hi));
        return {1'($urandom_range(0, 1)), ex, 7'($urandom)};
    endfunction

    task automatic send_beat(input logic [L-1:0][15:0] v);
        int g = 0;
        bus.i_bf16_vec = v;
        bus.i_valid    = 1'b1;
        @(negedge clk);
        while (!bus.o_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!bus.o_ready) chk("in_ready_timeout", bus.o_ready, 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_block(input bit gaps);
        logic [L-1:0][15:0] v;
        push_expected();
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < L; l++) v[l] = blk[b * L + l];
            send_beat(v);
            if (gaps && b < NB - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        chk("first_out_latency", bus.o_valid, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("idle_drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < K; i++) blk[i] = rand_bf16(lo, hi);
    endtask

    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == RDY_RAND) bus.i_ready = 1'($urandom_range(0, 1));
            else bus.i_ready = (ready_mode == RDY_ON);
            if (stall_left > 0 && bus.o_valid && out_idx == 1) begin
                bus.i_ready = 1'b0;
                stall_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", bus.o_valid, 1);
                chk("hold_vec", bus.o_mx_vec, h_vec);
                chk("hold_exp", bus.o_mx_exp, h_exp);
                chk("hold_last", bus.o_last, h_last);
            end
            if (bus.o_valid) chk("ready_low_in_drain", bus.o_ready, 0);
            held = 1'b0;
            if (bus.o_valid && !bus.i_ready) begin
                held   = 1'b1;
                h_vec  = bus.o_mx_vec;
                h_exp  = bus.o_mx_exp;
                h_last = bus.o_last;
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got vec %0h with no beat pending",
                             bus.o_mx_vec);
                end else begin
                    e = sb.pop_front();
                    chk("mx_vec", bus.o_mx_vec, e.vec);
                    chk("mx_exp", bus.o_mx_exp, e.scale);
                    chk("last", bus.o_last, e.last);
                    out_idx = e.last ? 0 : out_idx + 1;
                end
            end
        end
    end

    localparam logic [15:0] RND_PAT [8] = '{
        16'h3F81, 16'h3F83, 16'h3C00, 16'hBF81,
        16'h3F80, 16'hBF83, 16'hBC00, 16'h3F82
    };

    initial begin
        int g;
        bus.i_valid    = 1'b0;
        bus.i_bf16_vec = '0;
        #12;
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_exp", bus.o_mx_exp, 0);
        chk("rst_vec", bus.o_mx_vec, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < K; i++) blk[i] = 16'h3F80;
        send_block(1'b0);

        for (int i = 0; i < K; i++)
            blk[i] = $urandom_range(0, 1) ? 16'h3F80 : 16'hBF80;
        blk[$urandom_range(0, K - 1)] = 16'h4000;
        send_block(1'b1);

        for (int i = 0; i < K; i++) blk[i] = RND_PAT[i % 8];
        send_block(1'b0);

        ready_mode = RDY_RAND;
        fill_random(115, 135);
        blk[2 * L + 3] = 16'h7FC0;
        send_block(1'b1);
        fill_random(115, 135);
        send_block(1'b1);

        for (int i = 0; i < K; i++) blk[i] = 16'h0000;
        send_block(1'b0);

        wait_idle();
        ready_mode = RDY_ON;
        stall_left = 5;
        fill_random(118, 130);
        send_block(1'b0);

        wait_idle();
        ready_mode = RDY_RAND;
        for (int n = 0; n < 8; n++) begin
            fill_random(100, 140);
            send_block(1'b1);
        end
        for (int i = 0; i < K; i++)
            blk[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)), 7'($urandom)};
        send_block(1'b1);

        wait_idle();
        ready_mode = RDY_OFF;
        fill_random(115, 135);
        send_block(1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.o_valid, 0);
        chk("async_rst_ready", bus.o_ready, 1);
        chk("async_rst_exp", bus.o_mx_exp, 0);
        sb.delete();
        out_idx = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = RDY_ON;
        @(posedge clk);
        #1;
        fill_random(115, 135);
        send_block(1'b0);

        g = 0;
        while (sb.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
